// File: rtl/seven_segment_scan_decoder.sv
// rtl/seven_segment_scan_decoder.sv - recovers hex nibbles from a multiplexed 7-segment display bus
//
// Purpose: samples the segment/dp/digit-select bus, waits for a pattern to stay
// stable for STABLE_CYCLES samples, then decodes it once into the selected
// digit slot. Pulses frame_valid when every digit has been captured.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   seg_in       segments {g,f,e,d,c,b,a}, active-high
//   dp_in        decimal point, active-high
//   dig_sel      one-hot digit select, all-zero = blanking
//   clear_err    clears sticky error flags
//   value_out    decoded nibbles, digit i at [4i+3:4i]
//   dp_out       captured dp per digit
//   digit_valid  digit i captured since reset
//   frame_valid  one-cycle pulse when all digits have been seen
//   err_pattern  sticky: non-hex pattern on a one-hot capture
//   err_sel      sticky: multi-hot dig_sel on a capture
module seven_segment_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic                  dp_in,
  input  logic [DIGITS-1:0]     dig_sel,
  input  logic                  clear_err,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     dp_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  err_pattern,
  output logic                  err_sel
);

  localparam int         W      = 8 + DIGITS;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  typedef enum logic {QUALIFY, HELD} state_t;

  state_t                r_state;
  logic [W-1:0]          r_sample;
  logic [3:0]            r_cnt;
  logic [DIGITS-1:0]     r_seen;
  logic [4*DIGITS-1:0]   r_value;
  logic [DIGITS-1:0]     r_dp;
  logic [DIGITS-1:0]     r_dvalid;
  logic                  r_frame;
  logic                  r_err_pat;
  logic                  r_err_sel;

  logic [W-1:0]          w_in;
  logic                  w_same;
  logic [6:0]            w_seg;
  logic                  w_dp;
  logic [DIGITS-1:0]     w_sel;
  logic                  w_blank;
  logic                  w_multi;
  logic [3:0]            w_nib;
  logic                  w_hex_ok;
  logic [DIGITS-1:0]     w_new_seen;

  assign w_in   = {seg_in, dp_in, dig_sel};
  assign w_same = (w_in == r_sample);
  assign w_seg  = r_sample[W-1:DIGITS+1];
  assign w_dp   = r_sample[DIGITS];
  assign w_sel  = r_sample[DIGITS-1:0];

  assign w_blank    = (w_sel == '0);
  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign w_multi    = ((w_sel & (w_sel - DIGITS'(1))) != '0);
  assign w_new_seen = r_seen | w_sel;

  always_comb begin
    w_nib    = 4'h0;
    w_hex_ok = 1'b1;
    case (w_seg)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_hex_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= QUALIFY;
      r_sample  <= '0;
      r_cnt     <= 4'd0;
      r_seen    <= '0;
      r_value   <= '0;
      r_dp      <= '0;
      r_dvalid  <= '0;
      r_frame   <= 1'b0;
      r_err_pat <= 1'b0;
      r_err_sel <= 1'b0;
    end else begin
      r_sample <= w_in;
      if (!w_same) begin
        r_cnt <= 4'd1;
      end else if (r_cnt != STABLE) begin
        r_cnt <= r_cnt + 4'd1;
      end

      r_frame <= 1'b0;

      // Clear first so that an error captured on the same edge still wins.
      if (clear_err) begin
        r_err_pat <= 1'b0;
        r_err_sel <= 1'b0;
      end

      case (r_state)
        QUALIFY: begin
          if (r_cnt == STABLE) begin
            // r_sample has been stable for STABLE samples: capture it once.
            if (w_multi) begin
              r_err_sel <= 1'b1;
            end else if (!w_blank) begin
              if (!w_hex_ok) begin
                r_err_pat <= 1'b1;
              end else begin
                for (int i = 0; i < DIGITS; i++) begin
                  if (w_sel[i]) begin
                    r_value[4*i +: 4] <= w_nib;
                    r_dp[i]           <= w_dp;
                    r_dvalid[i]       <= 1'b1;
                  end
                end
                if (&w_new_seen) begin
                  r_frame <= 1'b1;
                  r_seen  <= '0;
                end else begin
                  r_seen  <= w_new_seen;
                end
              end
            end
            r_state <= w_same ? HELD : QUALIFY;
          end
        end
        HELD: begin
          if (!w_same) begin
            r_state <= QUALIFY;
          end
        end
        default: r_state <= QUALIFY;
      endcase
    end
  end

  assign value_out   = r_value;
  assign dp_out      = r_dp;
  assign digit_valid = r_dvalid;
  assign frame_valid = r_frame;
  assign err_pattern = r_err_pat;
  assign err_sel     = r_err_sel;

endmodule
